// File: rtl/wb_write_ctrl_if.sv
// wb_write_ctrl_if
//   Bundles the writeback controller's result handshakes and register-file
//   write port.
//   slave  : the controller itself. It receives the ALU and load results and
//            drives the handshakes, the write port, pend_mask and ld_count.
//   master : the producer/consumer side (execute/memory stages and register file).
//   Signals:
//     alu_valid/alu_waddr/alu_wdata/alu_ready  single-cycle ALU result handshake
//     ld_valid/ld_waddr/ld_wdata/ld_ready      load result handshake into the FIFO
//     wen/waddr/wdata                          registered register-file write port
//     pend_mask                                registers with a load still queued
//     ld_count                                 load FIFO occupancy
interface wb_write_ctrl_if #(
    parameter int DSIZE    = 32,
    parameter int ASIZE    = 5,
    parameter int LD_DEPTH = 4
);
    localparam int NREG = 1 << ASIZE;
    localparam int CW   = $clog2(LD_DEPTH) + 1;

    logic             alu_valid;
    logic [ASIZE-1:0] alu_waddr;
    logic [DSIZE-1:0] alu_wdata;
    logic             alu_ready;

    logic             ld_valid;
    logic [ASIZE-1:0] ld_waddr;
    logic [DSIZE-1:0] ld_wdata;
    logic             ld_ready;

    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic [NREG-1:0]  pend_mask;
    logic [CW-1:0]    ld_count;

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  ld_valid, ld_waddr, ld_wdata,
        output alu_ready, ld_ready,
        output wen, waddr, wdata, pend_mask, ld_count
    );

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output ld_valid, ld_waddr, ld_wdata,
        input  alu_ready, ld_ready,
        input  wen, waddr, wdata, pend_mask, ld_count
    );
endinterface

// File: rtl/wb_write_ctrl.sv
// wb_write_ctrl
//   Writeback controller that owns the single register-file write port.
//   It merges single-cycle ALU results with variable-latency load results.
//   Load results are buffered in an LD_DEPTH-entry FIFO. An ALU write is
//   held off while an older load to the same register is still queued,
//   which keeps per-register write order. A mask of queued load
//   destinations is exported for the hazard unit.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset
//     bus   wb_write_ctrl_if.slave (handshakes, write port, pend_mask, ld_count)
module wb_write_ctrl #(
    parameter int DSIZE    = 32,
    parameter int ASIZE    = 5,
    parameter int LD_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    wb_write_ctrl_if.slave  bus
);
    localparam int NREG = 1 << ASIZE;
    localparam int PW   = $clog2(LD_DEPTH);
    localparam int CW   = PW + 1;

    typedef struct packed {
        logic [ASIZE-1:0] addr;
        logic [DSIZE-1:0] data;
    } ld_ent_t;

    ld_ent_t          fifo [LD_DEPTH];
    logic [LD_DEPTH-1:0] occ, occ_nxt;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    ld_ent_t          head;

    logic             full, push, pop;
    logic             alu_blk, alu_ready, grant_ld;
    logic [NREG-1:0]  pend;

    logic             sel_vld;
    logic [ASIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_data;

    logic             wen_q;
    logic [ASIZE-1:0] waddr_q;
    logic [DSIZE-1:0] wdata_q;

    // Pending mask comes from registered FIFO state only. A popped entry
    // therefore stays visible until the cycle its write shows up on wen.
    always_comb begin
        pend = '0;
        for (int i = 0; i < LD_DEPTH; i++)
            if (occ[i]) pend[fifo[i].addr] = 1'b1;
        pend[0] = 1'b0;
    end

    always_comb begin
        head      = fifo[rd_ptr];
        full      = (count == CW'(LD_DEPTH));
        push      = bus.ld_valid && !full;
        // Block a younger ALU write to a register with a queued load (WAW).
        // Also block it when the FIFO is full, so the loads can drain.
        alu_blk   = bus.alu_valid && (pend[bus.alu_waddr] || full);
        alu_ready = bus.alu_valid && !alu_blk;
        grant_ld  = (count != '0) && (!bus.alu_valid || alu_blk);
        pop       = grant_ld;

        sel_vld   = alu_ready || grant_ld;
        sel_addr  = alu_ready ? bus.alu_waddr : head.addr;
        sel_data  = alu_ready ? bus.alu_wdata : head.data;

        occ_nxt = occ;
        if (pop)  occ_nxt[rd_ptr] = 1'b0;
        if (push) occ_nxt[wr_ptr] = 1'b1;
    end

    // FIFO storage needs no reset. Occupancy is tracked separately in occ.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{addr: bus.ld_waddr, data: bus.ld_wdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            occ     <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            occ <= occ_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // x0 writes complete their handshake but never assert wen.
            if (sel_vld) begin
                wen_q   <= (sel_addr != '0);
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end else begin
                wen_q   <= 1'b0;
            end
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.ld_ready  = !full;
    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.pend_mask = pend;
    assign bus.ld_count  = count;
endmodule

// File: tb/tb_wb_write_ctrl.sv
module tb_wb_write_ctrl;
    localparam int DSIZE = 32, ASIZE = 5, LD_DEPTH = 4, NREG = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_write_ctrl_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .LD_DEPTH(LD_DEPTH)) bus ();

    wb_write_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .LD_DEPTH(LD_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [ASIZE-1:0] a;
        logic [DSIZE-1:0] d;
    } ent_t;

    // Reference model: the load queue and the write-port contents expected after each edge.
    ent_t             q[$];
    logic             m_wen;
    logic [ASIZE-1:0] m_waddr;
    logic [DSIZE-1:0] m_wdata;
    logic [DSIZE-1:0] mrf [NREG];   // register file built from model writes
    logic [DSIZE-1:0] drf [NREG];   // register file built from DUT writes
    int tests = 0, fails = 0;

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_pend();
        logic [NREG-1:0] m = '0;
        foreach (q[i]) if (q[i].a != 0) m[q[i].a] = 1'b1;
        return m;
    endfunction

    // One clock of traffic. Entered and left at posedge+1.
    task automatic cyc(input bit av, input logic [ASIZE-1:0] aa, input logic [DSIZE-1:0] ad,
                       input bit lv, input logic [ASIZE-1:0] la, input logic [DSIZE-1:0] ldd);
        bit full, blk, ar, gl;
        logic [NREG-1:0] pm;
        ent_t e;
        bus.alu_valid = av; bus.alu_waddr = aa; bus.alu_wdata = ad;
        bus.ld_valid  = lv; bus.ld_waddr  = la; bus.ld_wdata  = ldd;
        #1;
        pm   = model_pend();
        full = (q.size() == LD_DEPTH);
        blk  = av && (pm[aa] || full);
        ar   = av && !blk;
        gl   = (q.size() != 0) && (!av || blk);
        check("alu_ready", 64'(bus.alu_ready), 64'(ar));
        check("ld_ready",  64'(bus.ld_ready),  64'(!full));
        check("ld_count",  64'(bus.ld_count),  64'(q.size()));
        check("pend_mask", 64'(bus.pend_mask), 64'(pm));
        @(posedge clk); #1;
        if (ar) begin
            m_wen = (aa != 0); m_waddr = aa; m_wdata = ad;
        end else if (gl) begin
            e = q.pop_front();
            m_wen = (e.a != 0); m_waddr = e.a; m_wdata = e.d;
        end else begin
            m_wen = 1'b0;
        end
        if (lv && !full) q.push_back('{a: la, d: ldd});
        if (m_wen) mrf[m_waddr] = m_wdata;
        if (bus.wen === 1'b1) drf[bus.waddr] = bus.wdata;
        check("wen",   64'(bus.wen),   64'(m_wen));
        check("waddr", 64'(bus.waddr), 64'(m_waddr));
        check("wdata", 64'(bus.wdata), 64'(m_wdata));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        bus.alu_valid = 0; bus.alu_waddr = '0; bus.alu_wdata = '0;
        bus.ld_valid  = 0; bus.ld_waddr  = '0; bus.ld_wdata  = '0;
        m_wen = 0; m_waddr = '0; m_wdata = '0;
        for (int i = 0; i < NREG; i++) begin mrf[i] = '0; drf[i] = '0; end

        // Reset state
        #2;
        check("rst_wen",   64'(bus.wen),       64'd0);
        check("rst_waddr", 64'(bus.waddr),     64'd0);
        check("rst_wdata", 64'(bus.wdata),     64'd0);
        check("rst_count", 64'(bus.ld_count),  64'd0);
        check("rst_pend",  64'(bus.pend_mask), 64'd0);
        check("rst_ldrdy", 64'(bus.ld_ready),  64'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // 1: single ALU write to r3, then an idle cycle
        cyc(1, 5'd3, 32'hA5, 0, '0, '0);
        check("t1_wen",   64'(bus.wen),   64'd1);
        check("t1_waddr", 64'(bus.waddr), 64'd3);
        check("t1_wdata", 64'(bus.wdata), 64'hA5);
        idle(1);
        check("t1_wen_off", 64'(bus.wen), 64'd0);

        // 2: four loads, no ALU traffic
        for (int i = 5; i <= 8; i++) cyc(0, '0, '0, 1, 5'(i), 32'h100 + 32'(i));
        idle(3);

        // 3: unblocked ALU stream keeps the FIFO from draining until it is full
        for (int i = 0; i < 6; i++) cyc(1, 5'd1, 32'h200 + 32'(i), 1, 5'(12 + i), 32'h300 + 32'(i));
        idle(6);

        // 4: queued load to r9 must land before the ALU write to r9
        cyc(1, 5'd2, 32'h22, 1, 5'd9, 32'h9999);
        for (int i = 0; i < 3; i++) cyc(1, 5'd9, 32'hA9A9, 0, '0, '0);
        idle(2);
        check("t4_r9", 64'(drf[9]), 64'hA9A9);

        // 5: ALU and load both target r0
        cyc(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
        cyc(0, '0, '0, 1, 5'd0, 32'h77);
        idle(3);
        check("t5_count", 64'(bus.ld_count), 64'd0);

        // 6: reset mid-drain with 3 entries queued and a load write in flight
        for (int i = 0; i < 4; i++) cyc(1, 5'd4, 32'h40 + 32'(i), 1, 5'(20 + i), 32'h500 + 32'(i));
        idle(1);
        #3 rst = 1'b0;
        #1;
        check("t6_wen",   64'(bus.wen),       64'd0);
        check("t6_count", 64'(bus.ld_count),  64'd0);
        check("t6_pend",  64'(bus.pend_mask), 64'd0);
        q.delete(); m_wen = 0; m_waddr = '0; m_wdata = '0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        idle(4);

        // Randomized traffic over a narrow address range to provoke hazards
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom(),
                ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom());
        idle(8);
        for (int r = 0; r < 8; r++) check("rf", 64'(drf[r]), 64'(mrf[r]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
